cci_tx_req_buffer: RTL and testbench
====================================

Name: cci_tx_req_buffer

Overview:
- TX-side request buffer between the loopback AFU and the reorder shim, on both CCI TX channels.
- Channel 0 carries read requests: 61-bit header. Channel 1 carries write requests: 61-bit header plus 512-bit data.
- Absorbs requests the AFU issues after downstream almost-full asserts.
- Presents its own registered almost-full to the AFU, with enough slack that no in-flight request is lost.
- Issues requests downstream in order, one per cycle, only while downstream almost-full is low.

Parameters:
- DEPTH, 16: entries per channel FIFO; power of 2, minimum 4.
- ALMFULL_SLACK, 8: free-entry margin; AFU almost-full asserts when occupancy >= DEPTH-ALMFULL_SLACK.

Ports:
- clk  in  1  AFU-domain clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- afu_tx_c0_header  in  61  read request header from AFU.
- afu_tx_c0_rdvalid  in  1  read request valid.
- afu_tx_c0_almostfull  out  1  registered channel 0 throttle to AFU.
- afu_tx_c1_header  in  61  write request header from AFU.
- afu_tx_c1_data  in  512  write data from AFU.
- afu_tx_c1_wrvalid  in  1  write request valid.
- afu_tx_c1_almostfull  out  1  registered channel 1 throttle to AFU.
- qlp_tx_c0_header  out  61  read header to reorder shim.
- qlp_tx_c0_rdvalid  out  1  read valid to reorder shim.
- qlp_tx_c0_almostfull  in  1  downstream channel 0 throttle.
- qlp_tx_c1_header  out  61  write header to reorder shim.
- qlp_tx_c1_data  out  512  write data to reorder shim.
- qlp_tx_c1_wrvalid  out  1  write valid to reorder shim.
- qlp_tx_c1_almostfull  in  1  downstream channel 1 throttle.
- c0_overflow  out  1  sticky flag: a channel 0 request was dropped.
- c1_overflow  out  1  sticky flag: a channel 1 request was dropped.

Behaviour:
- Channels are fully independent. Each has its own FIFO, count, almost-full and overflow logic; nothing is shared.
- Push (rising edge with valid=1):
  - Accepted if count < DEPTH, or if a pop occurs on the same edge.
  - Otherwise dropped, and cN_overflow is set. cN_overflow stays set until reset.
- Pop:
  - Occurs on an edge where count > 0 and qlp_tx_cN_almostfull (sampled on that edge) = 0.
  - The popped entry is loaded into output registers; valid is high for exactly one cycle per request.
  - With no pop, valid=0 and header/data hold their last value.
- Latency: no bypass.
  - A request sampled at edge E0 is first driven downstream in the cycle after edge E1 at the earliest.
  - Back-to-back pops sustain 1 request per cycle.
- Ordering: strict FIFO per channel.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged. At count=0, a push never pops on the same edge.
- Almost-full: afu_tx_cN_almostfull is registered as (count_next >= DEPTH-ALMFULL_SLACK), so it reflects occupancy after the current edge.
- Downstream almost-full is only a gate; it is never forwarded combinationally to the AFU.
- Reset (including mid-operation):
  - Pointers, counts, valids, headers, data and overflow flags go to 0.
  - FIFO contents are discarded; stale entries are never emitted after reset.
  - afu_tx_cN_almostfull = 1 while reset is high, then 0 on the first edge after reset deasserts (empty).
  - Pushes presented while reset is high are ignored.

Decomposition:
- Package cci_tx_buf_pkg:
  - CCI_TX_HDR_W=61, CCI_DATA_W=512.
  - typedef t_tx_c0_entry = header.
  - typedef t_tx_c1_entry = {header, data}.
- Sub-module cci_tx_req_fifo, parameterized by WIDTH, DEPTH and ALMFULL_SLACK:
  - Contains storage, pointers, count, almost-full, overflow and output registers.
  - Instantiated twice: WIDTH=61 for channel 0, WIDTH=573 for channel 1.

Test Plan:
1. Single C0 push, header 61'h0AB, downstream almfull=0 -> qlp_tx_c0_rdvalid high for exactly one cycle (the cycle after the second edge), header=61'h0AB; c0_overflow=0.
2. qlp_tx_c1_almostfull=1; push 8 writes, data=i, i=0..7 -> no wrvalid; afu_tx_c1_almostfull=1 from the cycle after the 8th push; release almfull -> 8 wrvalids on consecutive cycles, data 0..7 in order; almostfull drops once count<8.
3. Downstream almfull=1; push 17 C0 requests -> 16 stored, 17th dropped, c0_overflow=1 and sticky; release -> exactly 16 requests, in order.
4. FIFO at count=16 with push and pop on the same edge -> push accepted, count stays 16, no overflow; final drain includes the new entry last.
5. 10 C1 writes queued; assert reset after 3 have drained -> wrvalid=0 the next cycle; afu_tx_c1_almostfull=1 during reset, 0 after; no further wrvalid with no new pushes; overflow flags=0.
6. Concurrent traffic with qlp_tx_c0_almostfull toggling every 3 cycles and C1 unthrottled -> C1 throughput 1 per cycle, unaffected; both channels preserve order with no loss.

Source files
------------

// File: rtl/cci_tx_buf_pkg.sv
// Shared types for the CCI TX request buffer.
// Entry layouts for the read (c0) and write (c1) channel FIFOs.
package cci_tx_buf_pkg;

    localparam int CCI_TX_HDR_W = 61;
    localparam int CCI_DATA_W   = 512;

    typedef logic [CCI_TX_HDR_W-1:0] t_tx_c0_entry;

    typedef struct packed {
        logic [CCI_TX_HDR_W-1:0] header;
        logic [CCI_DATA_W-1:0]   data;
    } t_tx_c1_entry;

    localparam int C0_ENTRY_W = $bits(t_tx_c0_entry);
    localparam int C1_ENTRY_W = $bits(t_tx_c1_entry);

endpackage

// File: rtl/cci_tx_req_buffer_fifo.sv
// Single-channel request FIFO with registered output stage,
// registered almost-full throttle and sticky overflow flag.
module cci_tx_req_fifo #(
    parameter int WIDTH         = 61,
    parameter int DEPTH         = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pushValid,
    output logic             almostFull,
    output logic [WIDTH-1:0] popData,
    output logic             popValid,
    input  logic             downAlmostFull,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - ALMFULL_SLACK);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             doPop;
    logic             doPush;

    // A pop needs a stored entry, so an empty FIFO never bypasses a push.
    always_comb begin
        doPop     = (count != '0) && !downAlmostFull;
        doPush    = pushValid && ((count < FULL_CNT) || doPop);
        countNext = count + CW'(doPush) - CW'(doPop);
    end

    always_ff @(posedge clk) begin
        if (doPush && !reset) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            popValid   <= 1'b0;
            popData    <= '0;
            overflow   <= 1'b0;
            almostFull <= 1'b1;
        end else begin
            count      <= countNext;
            almostFull <= (countNext >= AF_CNT);
            popValid   <= doPop;
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr   <= rdPtr + PW'(1);
                popData <= mem[rdPtr];
            end
            if (pushValid && !doPush) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cci_tx_req_buffer.sv
// TX request buffer between the loopback AFU and the reorder shim.
// Two independent FIFOs: c0 read headers, c1 write header+data.
module cci_tx_req_buffer
    import cci_tx_buf_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [60:0]  afu_tx_c0_header,
    input  logic         afu_tx_c0_rdvalid,
    output logic         afu_tx_c0_almostfull,
    input  logic [60:0]  afu_tx_c1_header,
    input  logic [511:0] afu_tx_c1_data,
    input  logic         afu_tx_c1_wrvalid,
    output logic         afu_tx_c1_almostfull,
    output logic [60:0]  qlp_tx_c0_header,
    output logic         qlp_tx_c0_rdvalid,
    input  logic         qlp_tx_c0_almostfull,
    output logic [60:0]  qlp_tx_c1_header,
    output logic [511:0] qlp_tx_c1_data,
    output logic         qlp_tx_c1_wrvalid,
    input  logic         qlp_tx_c1_almostfull,
    output logic         c0_overflow,
    output logic         c1_overflow
);

    t_tx_c0_entry c0In;
    t_tx_c0_entry c0Out;
    t_tx_c1_entry c1In;
    t_tx_c1_entry c1Out;

    assign c0In        = afu_tx_c0_header;
    assign c1In.header = afu_tx_c1_header;
    assign c1In.data   = afu_tx_c1_data;

    cci_tx_req_fifo #(
        .WIDTH         (C0_ENTRY_W),
        .DEPTH         (DEPTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) c0Fifo (
        .clk            (clk),
        .reset          (reset),
        .pushData       (c0In),
        .pushValid      (afu_tx_c0_rdvalid),
        .almostFull     (afu_tx_c0_almostfull),
        .popData        (c0Out),
        .popValid       (qlp_tx_c0_rdvalid),
        .downAlmostFull (qlp_tx_c0_almostfull),
        .overflow       (c0_overflow)
    );

    cci_tx_req_fifo #(
        .WIDTH         (C1_ENTRY_W),
        .DEPTH         (DEPTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) c1Fifo (
        .clk            (clk),
        .reset          (reset),
        .pushData       (c1In),
        .pushValid      (afu_tx_c1_wrvalid),
        .almostFull     (afu_tx_c1_almostfull),
        .popData        (c1Out),
        .popValid       (qlp_tx_c1_wrvalid),
        .downAlmostFull (qlp_tx_c1_almostfull),
        .overflow       (c1_overflow)
    );

    assign qlp_tx_c0_header = c0Out;
    assign qlp_tx_c1_header = c1Out.header;
    assign qlp_tx_c1_data   = c1Out.data;

endmodule

// File: tb/tb_cci_tx_req_buffer.sv
// Randomized and directed bench for cci_tx_req_buffer against
// a queue-based reference model of both channels.
module tb_cci_tx_req_buffer;

    localparam int DEPTH = 16;
    localparam int SLACK = 8;

    logic         clk;
    logic         reset;
    logic [60:0]  c0Hdr;
    logic         c0Valid;
    logic         c0AfuAf;
    logic [60:0]  c1Hdr;
    logic [511:0] c1Data;
    logic         c1Valid;
    logic         c1AfuAf;
    logic [60:0]  q0Hdr;
    logic         q0Valid;
    logic         q0Af;
    logic [60:0]  q1Hdr;
    logic [511:0] q1Data;
    logic         q1Valid;
    logic         q1Af;
    logic         c0Ovf;
    logic         c1Ovf;

    int total = 0;
    int bad   = 0;

    logic [60:0]  mq0 [$];
    logic [572:0] mq1 [$];
    logic         ev0, ea0, eo0, ev1, ea1, eo1;
    logic [60:0]  eh0;
    logic [572:0] ee1;

    cci_tx_req_buffer #(.DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
        .clk                  (clk),
        .reset                (reset),
        .afu_tx_c0_header     (c0Hdr),
        .afu_tx_c0_rdvalid    (c0Valid),
        .afu_tx_c0_almostfull (c0AfuAf),
        .afu_tx_c1_header     (c1Hdr),
        .afu_tx_c1_data       (c1Data),
        .afu_tx_c1_wrvalid    (c1Valid),
        .afu_tx_c1_almostfull (c1AfuAf),
        .qlp_tx_c0_header     (q0Hdr),
        .qlp_tx_c0_rdvalid    (q0Valid),
        .qlp_tx_c0_almostfull (q0Af),
        .qlp_tx_c1_header     (q1Hdr),
        .qlp_tx_c1_data       (q1Data),
        .qlp_tx_c1_wrvalid    (q1Valid),
        .qlp_tx_c1_almostfull (q1Af),
        .c0_overflow          (c0Ovf),
        .c1_overflow          (c1Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [575:0] got,
                       input logic [575:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [60:0] rnd61();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[60:0];
    endfunction

    // One clock: drive inputs, advance the model at the edge, check after.
    task automatic step(input logic r, input logic v0, input logic [60:0] h0,
                        input logic a0, input logic v1, input logic [60:0] h1,
                        input logic [511:0] d1, input logic a1);
        reset   = r;
        c0Valid = v0;
        c0Hdr   = h0;
        q0Af    = a0;
        c1Valid = v1;
        c1Hdr   = h1;
        c1Data  = d1;
        q1Af    = a1;
        @(posedge clk);
        if (r) begin
            mq0.delete();
            mq1.delete();
            ev0 = 0; eh0 = '0; ea0 = 1; eo0 = 0;
            ev1 = 0; ee1 = '0; ea1 = 1; eo1 = 0;
        end else begin
            ev0 = (mq0.size() > 0) && !a0;
            if (ev0) eh0 = mq0.pop_front();
            if (v0) begin
                if (mq0.size() < DEPTH) mq0.push_back(h0);
                else eo0 = 1;
            end
            ea0 = (mq0.size() >= DEPTH - SLACK);
            ev1 = (mq1.size() > 0) && !a1;
            if (ev1) ee1 = mq1.pop_front();
            if (v1) begin
                if (mq1.size() < DEPTH) mq1.push_back({h1, d1});
                else eo1 = 1;
            end
            ea1 = (mq1.size() >= DEPTH - SLACK);
        end
        #1;
        chk("c0_valid", 576'(q0Valid), 576'(ev0));
        chk("c0_header", 576'(q0Hdr), 576'(eh0));
        chk("c0_almfull", 576'(c0AfuAf), 576'(ea0));
        chk("c0_overflow", 576'(c0Ovf), 576'(eo0));
        chk("c1_valid", 576'(q1Valid), 576'(ev1));
        chk("c1_entry", 576'({q1Hdr, q1Data}), 576'(ee1));
        chk("c1_almfull", 576'(c1AfuAf), 576'(ea1));
        chk("c1_overflow", 576'(c1Ovf), 576'(eo1));
    endtask

    task automatic idle(input int n, input logic a0, input logic a1);
        for (int i = 0; i < n; i++) step(0, 0, '0, a0, 0, '0, '0, a1);
    endtask

    initial begin
        step(1, 0, '0, 0, 0, '0, '0, 0);
        step(1, 1, 61'h5, 0, 1, 61'h6, 512'h7, 0);
        idle(2, 0, 0);

        // single read through the pipeline
        step(0, 1, 61'h0AB, 0, 0, '0, '0, 0);
        idle(4, 0, 0);

        // writes held back by downstream throttle, then released
        for (int i = 0; i < 8; i++)
            step(0, 0, '0, 0, 1, rnd61(), 512'(i), 1);
        idle(3, 0, 1);
        idle(10, 0, 0);

        // 17 reads into a full FIFO: last one dropped
        for (int i = 0; i < 17; i++)
            step(0, 1, 61'(100 + i), 1, 0, '0, '0, 0);
        idle(3, 1, 0);
        idle(20, 0, 0);
        step(1, 0, '0, 0, 0, '0, '0, 0);
        idle(1, 0, 0);

        // push and pop on the same edge at full
        for (int i = 0; i < 16; i++)
            step(0, 1, 61'(200 + i), 1, 0, '0, '0, 0);
        step(0, 1, 61'h777, 0, 0, '0, '0, 0);
        idle(20, 0, 0);

        // reset mid-drain
        for (int i = 0; i < 10; i++)
            step(0, 0, '0, 0, 1, rnd61(), rnd512(), 1);
        idle(3, 0, 0);
        step(1, 0, '0, 0, 0, '0, '0, 0);
        idle(12, 0, 0);

        // concurrent traffic, c0 throttle toggling every 3 cycles
        for (int i = 0; i < 60; i++)
            step(0, 1'(i % 2), rnd61(), 1'((i / 3) % 2),
                 1, rnd61(), rnd512(), 0);
        idle(24, 0, 0);

        // random traffic with occasional reset
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 6), rnd61(),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 6), rnd61(), rnd512(),
                 ($urandom_range(0, 9) < 4));
        idle(40, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
